cic_decim_nstage: RTL and testbench
===================================

# cic_decim_nstage

Parametrised N-stage CIC decimator that generalises the fixed 3-stage, R=32, M=2, 8-bit-in/26-bit-out decimator. It sits between the sample-rate front end and the downstream FIR compensation filter. It adds the following:
- a valid-qualified input stream, so gapped input is allowed
- a runtime-selectable decimation rate
- a configurable output width with scaled output
- an output valid strobe
- a synchronous flush

## Interface
Parameters:
- DIN_W, 8, input sample width (two's complement)
- STAGES, 3, number of integrator and comb stages N (1..6)
- MAX_RATE, 32, largest decimation rate R (power of two, 2..1024)
- DIFF_DLY, 2, comb differential delay M (1 or 2)
- DOUT_W, 16, output width; must satisfy DOUT_W ≤ ACC_W
- ACC_W, derived, DIN_W + STAGES*log2(MAX_RATE*DIFF_DLY); equals 26 at defaults

Ports:
- cic_clk  in  1  sole clock; all logic on rising edge
- cic_rstn  in  1  reset; **synchronous, active-low**
- cic_clr  in  1  synchronous flush; same effect as reset, and reloads the rate
- cic_rate  in  RATE_W=log2(MAX_RATE)+1  decimation rate R; sampled only at reset/flush
- cic_din_vld  in  1  input sample valid
- cic_din  in  DIN_W  input sample
- cic_dout_vld  out  1  one-cycle strobe per decimated output
- cic_dout  out  DOUT_W  decimated output sample, two's complement

## Operation
- Reset/flush: all integrators, comb delay lines, comb pipeline registers and the sample counter are cleared. cic_dout=0 and cic_dout_vld=0 from the next edge.
- Rate latch: on the edge where cic_rstn=0 or cic_clr=1, rate_q is loaded from cic_rate.
  - A value of 0 or greater than MAX_RATE is loaded as MAX_RATE.
  - Changes to cic_rate at any other time are ignored.
- Integrators (ACC_W wide, modulo arithmetic, wrap is intended):
  - They advance only on edges with cic_din_vld=1, with the input sign-extended.
  - The chain is registered: int[k] += old int[k-1].
  - All integrators hold when cic_din_vld=0.
- Sample counter:
  - Counts accepted samples 0..rate_q-1 and wraps to 0.
  - The edge accepting the sample at count rate_q-1 is the decimation strobe, dec_stb.
- Comb section:
  - On dec_stb, the last integrator value enters comb stage 0.
  - Each stage computes y = x − x[n−M] using an M-deep delay line that advances only when that stage fires.
  - The stages form a registered pipeline, one stage per cycle.
- Output scaling: cic_dout = comb result bits [ACC_W-1 : ACC_W-DOUT_W].
  - The gain is (R*M)^N, so output is full-scale only at R=MAX_RATE. Smaller rates give proportionally smaller output; no rate-dependent shift is applied.
- Simultaneous events: reset beats cic_clr, and cic_clr beats a valid input on the same edge. In both cases the sample is dropped.

## Timing
- cic_dout_vld pulses exactly STAGES+1 cycles after the dec_stb edge. cic_dout is valid in that same cycle and holds until the next strobe.
- Throughput: one output per rate_q accepted samples. A minimum rate of 2 guarantees the comb pipeline never overlaps.
- cic_din_vld may be held continuously high or gapped arbitrarily. Output values are independent of the gap pattern; only the output timing shifts.
- Reset or flush asserted mid-pipeline: any in-flight output is discarded and no cic_dout_vld is issued for it.

## Configuration
- Macro: CIC_DECIM_ROUND_EN.
- Defined: round-half-up before the slice.
  - Add 1<<(ACC_W-DOUT_W-1) to the ACC_W result.
  - Saturate at +max if the add would overflow the top DOUT_W bits.
- Undefined: plain truncation (floor). No rounding adder is present.

## Structure
- Package cic_pkg holds:
  - a clog2-style function
  - the ACC_W derivation function
  - the RATE_W derivation
  - parameter legality checks, applied as elaboration asserts in the module
- Sub-module cic_comb_stage: one comb stage (enable-qualified M-deep delay line, subtractor, output register). It is instantiated STAGES times through a generate loop. Integrators stay inline.

## Test plan
- DC step at defaults, constant din=1, rate=32: from the 8th output onward, cic_dout=256 every 32 accepted samples, with vld exactly 4 cycles after each strobe.
- Full-scale: din=+127 steady gives cic_dout=32512; din=−128 steady gives cic_dout=−32768, with no wrap error despite the integrators overflowing.
- Rate change: cic_clr with cic_rate=4, then din=1 steady. Result is cic_dout=0 without CIC_DECIM_ROUND_EN and 1 with it, and one output per 4 samples. Setting cic_rate=0 under clr gives the rate-32 cadence.
- Gapped input: the first DC-step test repeated with random 0–3 idle cycles between valids must produce an identical cic_dout sequence.
- Impulse: a single din=1 after reset must produce the expected (R*M)^N-scaled CIC impulse response, matched against a bit-true model for N=3, M=1, MAX_RATE=16.
- Reset mid-operation: assert cic_rstn=0 one cycle after a dec_stb. No vld follows, all outputs read 0, and the next run matches a fresh-reset run.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared helpers for the N-stage CIC decimator: log2 helper, accumulator and
// rate-port width derivations, and the parameter legality check.
package cic_pkg;

  // Smallest r such that (1 << r) >= v.
  function automatic int cic_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Integrator/comb width that holds the full (R*M)^N growth at MAX_RATE.
  function automatic int cic_acc_w(input int din_w, input int stages,
                                   input int max_rate, input int diff_dly);
    return din_w + stages * cic_clog2(max_rate * diff_dly);
  endfunction

  // Rate port must be able to carry MAX_RATE itself.
  function automatic int cic_rate_w(input int max_rate);
    return cic_clog2(max_rate) + 1;
  endfunction

  // Legal parameter space of the decimator.
  function automatic bit cic_params_ok(input int din_w, input int stages,
                                       input int max_rate, input int diff_dly,
                                       input int dout_w);
    bit ok;
    ok = 1'b1;
    if (din_w < 1) ok = 1'b0;
    if (stages < 1 || stages > 6) ok = 1'b0;
    if (max_rate < 2 || max_rate > 1024) ok = 1'b0;
    if ((max_rate & (max_rate - 1)) != 0) ok = 1'b0;
    if (diff_dly < 1 || diff_dly > 2) ok = 1'b0;
    if (dout_w < 1 || dout_w > cic_acc_w(din_w, stages, max_rate, diff_dly)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x[n-M] with an M-deep delay line that only
// advances when the stage fires, followed by a registered output.
module cic_comb_stage #(
  parameter int W        = 26,
  parameter int DIFF_DLY = 2
) (
  input  logic                i_clk,
  input  logic                i_flush,
  input  logic                i_en,
  input  logic signed [W-1:0] i_x,
  output logic                o_vld,
  output logic signed [W-1:0] o_y
);

  logic signed [W-1:0] r_dly [DIFF_DLY];
  logic signed [W-1:0] r_y;
  logic                r_vld;

  // Difference against the oldest delay tap and shift the delay line on enable.
  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_vld <= 1'b0;
      r_y   <= '0;
      for (int i = 0; i < DIFF_DLY; i++) r_dly[i] <= '0;
    end else begin
      r_vld <= i_en;
      if (i_en) begin
        r_y      <= i_x - r_dly[DIFF_DLY-1];
        r_dly[0] <= i_x;
        for (int i = 1; i < DIFF_DLY; i++) r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign o_vld = r_vld;
  assign o_y   = r_y;

endmodule

// File: rtl/cic_decim_nstage.sv
// Parametrised N-stage CIC decimator with valid-qualified input, runtime
// decimation rate (latched at reset/flush), scaled output and output strobe.
// Optional build macro CIC_DECIM_ROUND_EN: round-half-up with positive
// saturation before the output slice; otherwise the output is truncated.
module cic_decim_nstage
  import cic_pkg::*;
#(
  parameter int  DIN_W    = 8,
  parameter int  STAGES   = 3,
  parameter int  MAX_RATE = 32,
  parameter int  DIFF_DLY = 2,
  parameter int  DOUT_W   = 16,
  localparam int ACC_W    = cic_acc_w(DIN_W, STAGES, MAX_RATE, DIFF_DLY),
  localparam int RATE_W   = cic_rate_w(MAX_RATE)
) (
  input  logic                     cic_clk,
  input  logic                     cic_rstn,
  input  logic                     cic_clr,
  input  logic [RATE_W-1:0]        cic_rate,
  input  logic                     cic_din_vld,
  input  logic signed [DIN_W-1:0]  cic_din,
  output logic                     cic_dout_vld,
  output logic signed [DOUT_W-1:0] cic_dout
);

  if (!cic_params_ok(DIN_W, STAGES, MAX_RATE, DIFF_DLY, DOUT_W)) begin : g_param_check
    $error("cic_decim_nstage: illegal parameter combination");
  end

  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(MAX_RATE);

`ifdef CIC_DECIM_ROUND_EN
  localparam int                RND_SH   = (ACC_W > DOUT_W) ? (ACC_W - DOUT_W - 1) : 0;
  localparam logic [ACC_W:0]    RND_HALF = (ACC_W > DOUT_W) ? ((ACC_W+1)'(1) << RND_SH) : '0;

  // Round half up, clamping the only possible overflow (positive) to +max.
  function automatic logic signed [DOUT_W-1:0] f_scale(input logic signed [ACC_W-1:0] v);
    logic [ACC_W:0] s;
    s = {v[ACC_W-1], v} + RND_HALF;
    if (s[ACC_W] != s[ACC_W-1]) return {1'b0, {(DOUT_W-1){1'b1}}};
    return s[ACC_W-1 -: DOUT_W];
  endfunction
`else
  // Plain truncation of the low-order bits (floor).
  function automatic logic signed [DOUT_W-1:0] f_scale(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1 -: DOUT_W];
  endfunction
`endif

  logic                     w_flush;
  logic                     w_dec_stb;
  logic signed [ACC_W-1:0]  w_din_ext;
  logic [RATE_W-1:0]        r_rate_q;
  logic [RATE_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0]  r_int [STAGES];
  logic signed [ACC_W-1:0]  r_cin_p0;
  logic                     r_vld_p0;
  logic signed [ACC_W-1:0]  w_x [STAGES+1];
  logic                     w_v [STAGES+1];
  logic signed [DOUT_W-1:0] r_dout;
  logic                     r_dout_vld;

  // Reset dominates flush; both clear everything and reload the rate.
  assign w_flush   = !cic_rstn || cic_clr;
  assign w_din_ext = {{(ACC_W-DIN_W){cic_din[DIN_W-1]}}, cic_din};
  assign w_dec_stb = cic_din_vld && (r_cnt == r_rate_q - 1'b1);

  // Latch the decimation rate only on reset/flush; illegal values fall back to MAX_RATE.
  always_ff @(posedge cic_clk) begin
    if (w_flush) begin
      if (cic_rate == '0 || cic_rate > RATE_MAX) r_rate_q <= RATE_MAX;
      else                                       r_rate_q <= cic_rate;
    end
  end

  // Registered integrator chain and sample counter, advancing only on valid input.
  always_ff @(posedge cic_clk) begin
    if (w_flush) begin
      r_cnt <= '0;
      for (int k = 0; k < STAGES; k++) r_int[k] <= '0;
    end else if (cic_din_vld) begin
      r_int[0] <= r_int[0] + w_din_ext;
      for (int k = 1; k < STAGES; k++) r_int[k] <= r_int[k] + r_int[k-1];
      r_cnt <= w_dec_stb ? '0 : r_cnt + 1'b1;
    end
  end

  // ---- stage p0: capture the last integrator on the decimation strobe ----
  always_ff @(posedge cic_clk) begin
    if (w_flush) begin
      r_vld_p0 <= 1'b0;
      r_cin_p0 <= '0;
    end else begin
      r_vld_p0 <= w_dec_stb;
      if (w_dec_stb) r_cin_p0 <= r_int[STAGES-1];
    end
  end

  assign w_x[0] = r_cin_p0;
  assign w_v[0] = r_vld_p0;

  // ---- comb pipeline: one registered stage per cycle ----
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    cic_comb_stage #(
      .W        (ACC_W),
      .DIFF_DLY (DIFF_DLY)
    ) u_comb (
      .i_clk   (cic_clk),
      .i_flush (w_flush),
      .i_en    (w_v[k]),
      .i_x     (w_x[k]),
      .o_vld   (w_v[k+1]),
      .o_y     (w_x[k+1])
    );
  end

  // ---- output stage: scale the comb result and hold it until the next strobe ----
  always_ff @(posedge cic_clk) begin
    if (w_flush) begin
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_dout_vld <= w_v[STAGES];
      if (w_v[STAGES]) r_dout <= f_scale(w_x[STAGES]);
    end
  end

  assign cic_dout_vld = r_dout_vld;
  assign cic_dout     = r_dout;

endmodule

// File: tb/tb_cic_decim_nstage.sv
// Self-checking bench for cic_decim_nstage: default build (N=3, R=32, M=2)
// plus a second instance (N=3, R=16, M=1) for the impulse response.
`timescale 1ns/1ps
module tb_cic_decim_nstage;

`ifdef CIC_DECIM_ROUND_EN
  localparam int R4_EXP = 1;
`else
  localparam int R4_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, clr, dvld;
  logic [5:0]        rate;
  logic signed [7:0] din;
  logic              a_vld, b_vld;
  logic signed [15:0] a_dout, b_dout;

  cic_decim_nstage u_dut_a (
    .cic_clk(clk), .cic_rstn(rstn), .cic_clr(clr), .cic_rate(rate),
    .cic_din_vld(dvld), .cic_din(din), .cic_dout_vld(a_vld), .cic_dout(a_dout)
  );

  cic_decim_nstage #(.STAGES(3), .MAX_RATE(16), .DIFF_DLY(1)) u_dut_b (
    .cic_clk(clk), .cic_rstn(rstn), .cic_clr(clr), .cic_rate(rate[4:0]),
    .cic_din_vld(dvld), .cic_din(din), .cic_dout_vld(b_vld), .cic_dout(b_dout)
  );

  typedef struct { int val; int due; } exp_t;
  typedef struct { int din; int rate; bit clr; int expv; } vec_t;

  exp_t sbq[$];
  int   got[$];
  int   ref_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  bit   sel = 1'b0;

  logic              sel_vld;
  logic signed [15:0] sel_dout;
  assign sel_vld  = sel ? b_vld  : a_vld;
  assign sel_dout = sel ? b_dout : a_dout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int     cfg_n, cfg_m, cfg_accw, cfg_doutw, cfg_maxr;
  longint mi[6];
  longint md[6][2];
  int     mcnt, mrate;

  function automatic longint wrapv(input longint v);
    longint m, r;
    m = longint'(1) << cfg_accw;
    r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic int mscale(input longint v);
    int sh;
    longint r;
    sh = cfg_accw - cfg_doutw;
`ifdef CIC_DECIM_ROUND_EN
    r = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (r > (longint'(1) << (cfg_doutw - 1)) - 1) r = (longint'(1) << (cfg_doutw - 1)) - 1;
`else
    r = v >>> sh;
`endif
    return int'(r);
  endfunction

  task automatic model_reset(input int r);
    for (int k = 0; k < 6; k++) begin
      mi[k] = 0; md[k][0] = 0; md[k][1] = 0;
    end
    mcnt  = 0;
    mrate = (r == 0 || r > cfg_maxr) ? cfg_maxr : r;
  endtask

  task automatic model_sample(input int x);
    longint old[6];
    longint v, y;
    if (mcnt == mrate - 1) begin
      v = mi[cfg_n-1];
      for (int k = 0; k < cfg_n; k++) begin
        y = wrapv(v - md[k][cfg_m-1]);
        md[k][1] = md[k][0];
        md[k][0] = v;
        v = y;
      end
      sbq.push_back('{val: mscale(v), due: cyc + 1 + cfg_n + 1});
      mcnt = 0;
    end else begin
      mcnt++;
    end
    old = mi;
    mi[0] = wrapv(old[0] + x);
    for (int k = 1; k < cfg_n; k++) mi[k] = wrapv(old[k] + old[k-1]);
  endtask

  task automatic use_a();
    sel = 1'b0; cfg_n = 3; cfg_m = 2; cfg_accw = 26; cfg_doutw = 16; cfg_maxr = 32;
  endtask

  task automatic use_b();
    sel = 1'b1; cfg_n = 3; cfg_m = 1; cfg_accw = 20; cfg_doutw = 16; cfg_maxr = 16;
  endtask

  // ---------------- scoreboard monitor ----------------
  exp_t mon_e;
  int   mon_v;
  always @(posedge clk) begin
    #2;
    mon_v = int'(sel_dout);
    if (sel_vld) begin
      got.push_back(mon_v);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_vld actual vld=1 dout=%0d required vld=0 (cycle %0d)", mon_v, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("dout", mon_v, mon_e.val);
        chk("latency_cycle", cyc, mon_e.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
      mon_e = sbq.pop_front();
      checks++; errors++;
      $display("FAIL missing_vld actual vld=0 required vld=1 dout=%0d due %0d (cycle %0d)", mon_e.val, mon_e.due, cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int x, input bit v);
    @(negedge clk);
    dvld = v;
    din  = x[7:0];
    if (v) model_sample(x);
  endtask

  // A valid sample with din=100 is offered on the reset/flush edge; it must be dropped.
  task automatic do_reset(input int r, input bit use_clr);
    @(negedge clk);
    sbq.delete();
    if (use_clr) clr = 1'b1; else rstn = 1'b0;
    rate = r[5:0];
    dvld = 1'b1;
    din  = 8'sd100;
    @(negedge clk);
    rstn = 1'b1; clr = 1'b0; dvld = 1'b0; din = '0;
    model_reset(r);
    chk("reset_dout", int'(sel_dout), 0);
    chk("reset_vld", int'(sel_vld), 0);
  endtask

  task automatic drain();
    int t;
    @(negedge clk);
    dvld = 1'b0;
    t = 0;
    while (sbq.size() > 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", sbq.size());
      sbq.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_const(input int x, input int nsamp, input int gapmax);
    for (int i = 0; i < nsamp; i++) begin
      repeat ($urandom_range(0, gapmax)) send(0, 1'b0);
      send(x, 1'b1);
    end
    drain();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  vec_t vt[8];
  int   reff;

  initial begin
    rstn = 1'b0; clr = 1'b0; dvld = 1'b0; din = '0; rate = 6'd32;
    use_a();
    model_reset(32);

    vt[0] = '{din: 1,    rate: 32, clr: 1'b0, expv: 256};
    vt[1] = '{din: 127,  rate: 32, clr: 1'b1, expv: 32512};
    vt[2] = '{din: -128, rate: 32, clr: 1'b0, expv: -32768};
    vt[3] = '{din: -1,   rate: 32, clr: 1'b1, expv: -256};
    vt[4] = '{din: 3,    rate: 16, clr: 1'b1, expv: 96};
    vt[5] = '{din: 1,    rate: 4,  clr: 1'b1, expv: R4_EXP};
    vt[6] = '{din: 1,    rate: 0,  clr: 1'b1, expv: 256};
    vt[7] = '{din: 1,    rate: 40, clr: 1'b1, expv: 256};

    // Table-driven steady-state vectors on the default instance.
    for (int i = 0; i < 8; i++) begin
      use_a();
      do_reset(vt[i].rate, vt[i].clr);
      got.delete();
      reff = (vt[i].rate == 0 || vt[i].rate > 32) ? 32 : vt[i].rate;
      run_const(vt[i].din, 10 * reff, 0);
      chk("vec_outputs", got.size(), 10);
      chk("vec_steady", (got.size() == 10) ? got[9] : 99999, vt[i].expv);
    end

    // Continuous DC step as a reference, then the same with random gaps.
    use_a();
    do_reset(32, 1'b0);
    got.delete();
    run_const(1, 320, 0);
    ref_q = got;
    chk("ref_outputs", ref_q.size(), 10);

    do_reset(32, 1'b0);
    got.delete();
    run_const(1, 320, 3);
    chk("gap_outputs", got.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < got.size(); i++) chk("gap_seq", got[i], ref_q[i]);

    // Reset one cycle after a decimation strobe: the in-flight output is dropped.
    do_reset(32, 1'b0);
    for (int i = 0; i < 64; i++) send(1, 1'b1);
    @(negedge clk);
    sbq.delete();
    rstn = 1'b0;
    dvld = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset(32);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_dout", int'(sel_dout), 0);
      chk("midrst_vld", int'(sel_vld), 0);
    end
    got.delete();
    run_const(1, 320, 0);
    chk("rerun_outputs", got.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < got.size(); i++) chk("rerun_seq", got[i], ref_q[i]);

    // Impulse response on the N=3, M=1, MAX_RATE=16 instance.
    use_b();
    do_reset(16, 1'b0);
    got.delete();
    send(1, 1'b1);
    for (int i = 0; i < 16 * 6 - 1; i++) send(0, 1'b1);
    drain();
    chk("impulse_outputs", got.size(), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
